// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer.
// TDM_PARITY_EN adds a trailing even-parity bit to every slot.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } state_e;

    // Number of serial bits occupied by one channel slot.
    function automatic int unsigned slot_len(input int unsigned width);
`ifdef TDM_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // High when the vector holds an odd number of ones (even parity violated).
    function automatic logic parity_odd(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// Slot deserialiser: MSB-first shift register with bit counter and slot-done flag.
// Slot length grows by one parity bit when TDM_PARITY_EN is defined.
module tdm_shift_in
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN   = slot_len(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           clear,
    input  logic           load,
    input  logic           shift,
    output logic [LEN-1:0] word_next,
    output logic           done
);

    localparam int unsigned CW = $clog2(LEN + 1);

    logic [LEN-1:0] sreg_q, sreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Word as it stands once the current bit is shifted in.
    assign word_next = {sreg_q[LEN-2:0], din};
    assign done      = shift && (cnt_q == CW'(LEN - 1));

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (load) begin
            sreg_d = {{(LEN-1){1'b0}}, din};
            cnt_d  = CW'(1);
        end else if (shift) begin
            sreg_d = word_next;
            cnt_d  = done ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM receiver: hunts for frame sync, deserialises ch0 then ch1 slots.
// TDM_PARITY_EN adds a per-slot even-parity bit and the par_err output.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             sync,
    input  logic             en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             valid0,
    output logic             valid1,
    output logic             sync_err,
`ifdef TDM_PARITY_EN
    output logic             par_err,
`endif
    output logic             busy
);

    localparam int unsigned LEN = slot_len(WIDTH);

    state_e           state_q, state_d;
    logic             load, shift, clear, done;
    logic [LEN-1:0]   word_next;
    logic [WIDTH-1:0] data, out0_d, out1_d;
    logic             valid0_d, valid1_d, sync_err_d;

    // Data bits sit above the optional parity bit.
    assign data = word_next[LEN-1 -: WIDTH];

    tdm_shift_in #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .clear     (clear),
        .load      (load),
        .shift     (shift),
        .word_next (word_next),
        .done      (done)
    );

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        out0_d     = out0;
        out1_d     = out1;
        valid0_d   = 1'b0;
        valid1_d   = 1'b0;
        sync_err_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (en && sync) begin
                    load    = 1'b1;
                    state_d = CH0;
                end else begin
                    clear = 1'b1;
                end
            end
            CH0, CH1: begin
                // A sync mid-frame abandons the partial slot and restarts the frame.
                if (en && sync) begin
                    load       = 1'b1;
                    sync_err_d = 1'b1;
                    state_d    = CH0;
                end else if (en) begin
                    shift = 1'b1;
                    if (done) begin
                        if (state_q == CH0) begin
                            out0_d   = data;
                            valid0_d = 1'b1;
                            state_d  = CH1;
                        end else begin
                            out1_d   = data;
                            valid1_d = 1'b1;
                            state_d  = HUNT;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            out0     <= '0;
            out1     <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            sync_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out0     <= out0_d;
            out1     <= out1_d;
            valid0   <= valid0_d;
            valid1   <= valid1_d;
            sync_err <= sync_err_d;
            busy     <= (state_d != HUNT);
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= done && parity_odd(32'(word_next));
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2: directed frames then random traffic,
// compared every cycle against a bit-position model of the frame format.
module tb_tdm_demux2;

    localparam int WIDTH = 4;
`ifdef TDM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = WIDTH + PB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             sync = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] out0, out1;
    logic             valid0, valid1, sync_err, busy;
    logic             par_err_w;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: bits consumed since the last accepted sync.
    bit               active;
    int               pos;
    logic [31:0]      acc;
    logic [WIDTH-1:0] e_out0, e_out1;
    logic             e_v0, e_v1, e_se, e_pe, e_busy;

    tdm_demux2 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sync     (sync),
        .en       (en),
        .out0     (out0),
        .out1     (out1),
        .valid0   (valid0),
        .valid1   (valid1),
        .sync_err (sync_err),
`ifdef TDM_PARITY_EN
        .par_err  (par_err_w),
`endif
        .busy     (busy)
    );

`ifndef TDM_PARITY_EN
    assign par_err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".out0"}, 32'(out0), 32'(e_out0));
        check({ph, ".out1"}, 32'(out1), 32'(e_out1));
        check({ph, ".valid0"}, 32'(valid0), 32'(e_v0));
        check({ph, ".valid1"}, 32'(valid1), 32'(e_v1));
        check({ph, ".sync_err"}, 32'(sync_err), 32'(e_se));
        check({ph, ".busy"}, 32'(busy), 32'(e_busy));
`ifdef TDM_PARITY_EN
        check({ph, ".par_err"}, 32'(par_err_w), 32'(e_pe));
`endif
    endtask

    task automatic model_reset();
        active = 0;
        pos    = 0;
        acc    = '0;
        e_out0 = '0;
        e_out1 = '0;
        e_v0   = 0;
        e_v1   = 0;
        e_se   = 0;
        e_pe   = 0;
        e_busy = 0;
    endtask

    task automatic model_edge(input logic b, input logic s, input logic e);
        e_v0 = 0;
        e_v1 = 0;
        e_se = 0;
        e_pe = 0;
        if (e) begin
            if (s) begin
                if (active) e_se = 1;
                active = 1;
                pos    = 1;
                acc    = 32'(b);
            end else if (active) begin
                acc = (acc << 1) | 32'(b);
                pos++;
                if (pos == L) begin
                    e_out0 = WIDTH'(acc >> PB);
                    e_v0   = 1;
                    e_pe   = (PB != 0) && (^acc);
                    acc    = '0;
                end else if (pos == 2 * L) begin
                    e_out1 = WIDTH'(acc >> PB);
                    e_v1   = 1;
                    e_pe   = (PB != 0) && (^acc);
                    active = 0;
                end
            end
        end
        e_busy = active;
    endtask

    task automatic step(input logic b, input logic s, input logic e);
        din  = b;
        sync = s;
        en   = e;
        @(posedge clk);
        model_edge(b, s, e);
        #1;
        check_all("step");
    endtask

    // One slot MSB first; gap inserts an en=0 cycle (with random sync) after every bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit s, input bit gap,
                             input bit pflip);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(w[i], s && (i == WIDTH - 1), 1'b1);
            if (gap) step(1'($urandom), 1'($urandom), 1'b0);
        end
`ifdef TDM_PARITY_EN
        step((^w) ^ pflip, 1'b0, 1'b1);
        if (gap) step(1'($urandom), 1'($urandom), 1'b0);
`else
        if (pflip) $display("note: parity flip ignored without parity bit");
`endif
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input bit gap);
        send_word(a, 1'b1, gap, 1'b0);
        send_word(b, 1'b0, gap, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Plain frame, then idle bits discarded while hunting.
        send_frame(4'hA, 4'h6, 1'b0);
        check("frame.out0", 32'(out0), 32'hA);
        check("frame.out1", 32'(out1), 32'h6);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Same frame with en gaps; sync during gaps must be ignored.
        send_frame(4'hA, 4'h6, 1'b1);

        // Sync inside ch1 aborts the slot and restarts the frame.
        send_word(4'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        send_frame(4'h3, 4'h9, 1'b0);
        check("resync.out0", 32'(out0), 32'h3);

        // Back-to-back frames.
        send_frame(4'hA, 4'h6, 1'b0);
        send_frame(4'h5, 4'hC, 1'b0);
        check("b2b.out1", 32'(out1), 32'hC);

        // Reset in the middle of ch0, then a fresh frame.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        do_reset();
        send_frame(4'h7, 4'h2, 1'b0);
        check("postrst.out0", 32'(out0), 32'h7);

`ifdef TDM_PARITY_EN
        // Bad parity on ch0 then good parity.
        send_word(4'hA, 1'b1, 1'b0, 1'b1);
        send_word(4'h6, 1'b0, 1'b0, 1'b0);
        send_frame(4'hA, 4'h6, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux2.md
# tdm_demux2

Two-channel time-division demultiplexer, the receive end of a 2:1 TDM link that interleaves two channels onto one serial wire. The block hunts for a frame sync, deserialises the channel-0 slot, then the channel-1 slot, MSB first, and presents each as a registered parallel word with a one-cycle valid strobe. It sits behind the serial link pin and ahead of per-channel consumers.

## Interface
- WIDTH, 4, data bits per channel slot (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  serial data bit
- sync  input  1  marks bit 0 of channel-0 slot (frame start)
- en  input  1  bit enable; a bit is consumed only on edges with en=1
- out0  output  WIDTH  last complete channel-0 word
- out1  output  WIDTH  last complete channel-1 word
- valid0  output  1  one-cycle pulse: out0 just updated
- valid1  output  1  one-cycle pulse: out1 just updated
- sync_err  output  1  one-cycle pulse: sync seen mid-frame
- busy  output  1  high while in CH0 or CH1
- par_err  output  1  only with TDM_PARITY_EN; pulses with valid0/valid1 on parity mismatch

## Operation
- States: HUNT, CH0, CH1. Reset → HUNT.
- HUNT: en&&sync → CH0; that bit is ch0 bit WIDTH-1 (MSB), count=1. en&&!sync: bit discarded. en=0: nothing.
- CH0: each en edge shifts din in, count+1. Slot complete (count reaches slot length) → out0 loaded, valid0 next cycle, count=0, → CH1.
- CH1: same; on completion out1 loaded, valid1, → HUNT. Next frame's sync accepted on the very next en edge (back-to-back frames, no gap).
- en&&sync while in CH0/CH1 (any bit position, including last): sync_err pulses, partial word discarded, no valid for that slot, frame restarts with this bit as ch0 MSB (state CH0, count=1).
- sync with en=0 ignored in all states.
- out0/out1 hold their value until their own slot completes; the other channel never disturbs them.
- busy = (state != HUNT).

## Timing
- All outputs registered. Reset values: out0=out1=0, valid0=valid1=sync_err=par_err=0, busy=0.
- Sync sampled at edge E (en=1 throughout): out0/valid0 change at edge E+WIDTH-1 (the edge sampling the final ch0 bit); valid0 high for the cycle following that edge only. out1/valid1 at edge E+2·WIDTH-1.
- With en gaps, latency stretches by the number of en=0 cycles; strobes remain exactly one cycle.
- sync_err asserted in the cycle after the offending edge.
- rst_n low mid-frame: immediate return to HUNT, all outputs cleared, partial data lost; first edge after release acts as HUNT.

## Configuration
- TDM_PARITY_EN defined: each slot is WIDTH data bits followed by one even-parity bit (slot length WIDTH+1); word loaded and valid pulsed regardless, par_err pulses in the same cycle as the strobe if parity over data+parity bit is odd. Port par_err present.
- Undefined: slot length WIDTH, no parity bit, no par_err port.

## Structure
- Package tdm_pkg: state encoding constants (HUNT=2'd0, CH0=2'd1, CH1=2'd2), even-parity function, slot-length helper.
- One sub-module, tdm_shift_in: WIDTH(+1) shift register with bit counter, load/clear/shift controls and a slot-done flag; top holds FSM and output registers.

## Test plan
- Reset: assert rst_n=0 at ch0 bit 2 → out0=out1=0, valid*/sync_err/busy=0; after release, a fresh frame decodes correctly.
- Frame ch0=4'b1010, ch1=4'b0110, en=1, sync at edge 1 → out0=4'hA with valid0 after edge 4, out1=4'h6 with valid1 after edge 8, busy low after edge 8.
- Same frame with en=0 every other cycle → identical words, strobes after edges 7 and 15, each one cycle wide.
- Sync at ch1 bit 2 → sync_err one cycle, no valid1, out1 unchanged, new frame ch0=4'b0011 decodes to out0=4'h3.
- Back-to-back frames (second sync at edge 9, ch0=4'h5, ch1=4'hC) → out0=4'h5 after edge 12 while out1 still 4'h6, out1=4'hC after edge 16.
- TDM_PARITY_EN: ch0=4'b1010 with parity bit 1 → valid0 with par_err=1; parity bit 0 → par_err=0.
